mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported synchronous RAM between the IF stage (instruction fetch) and the
//  MEM stage (lw/sw). Arbitrates, sequences each access, returns read data and drives per-stage stalls.
//  Sits between the pipeline registers and the unified memory, ahead of the mem forwarding mux.
// PARAMETERS
//  DATA_WIDTH    32  data bus width
//  ADDR_WIDTH    32  address bus width
//  MEM_LATENCY   2   cycles from the ram_en cycle to valid ram_rdata (>=1)
//  STARVE_LIMIT  4   max consecutive MEM grants while if_req is pending (>=1)
// PORTS
//  clk         in   1           clock, rising edge
//  rst_n       in   1           synchronous reset, active-low
//  if_req      in   1           fetch request; held until if_ready
//  if_addr     in   ADDR_WIDTH  fetch address
//  if_rdata    out  DATA_WIDTH  fetched word; valid when if_ready=1, held until next IF read
//  if_ready    out  1           one-cycle completion pulse for IF
//  mem_rd      in   1           load request; held until mem_ready
//  mem_wr      in   1           store request; held until mem_ready
//  mem_addr    in   ADDR_WIDTH  load/store address
//  mem_wdata   in   DATA_WIDTH  store data
//  mem_rdata   out  DATA_WIDTH  load data; valid when mem_ready=1, held until next MEM read
//  mem_ready   out  1           one-cycle completion pulse for MEM
//  stall_if    out  1           if_req & ~if_ready (combinational)
//  stall_mem   out  1           (mem_rd|mem_wr) & ~mem_ready (combinational)
//  ram_en      out  1           RAM access strobe, registered, high exactly one cycle per access
//  ram_we      out  1           RAM write enable, registered, valid with ram_en
//  ram_addr    out  ADDR_WIDTH  RAM address, registered
//  ram_wdata   out  DATA_WIDTH  RAM write data, registered
//  ram_rdata   in   DATA_WIDTH  RAM read data
//  proto_err   out  1           sticky: mem_rd & mem_wr were seen high together at a grant
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE, starve_cnt=0, proto_err=0. All registered outputs
//   and both rdata registers become 0. Any in-flight access is abandoned and no ready is pulsed.
//  FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  IDLE: requests are sampled only in this state. With no request, stay in IDLE.
//   With any request, latch the winner, its address and wdata, then go to ISSUE.
//  Arbitration: MEM wins over IF. Exception: if_req=1 and starve_cnt==STARVE_LIMIT, then IF wins.
//  starve_cnt: +1 on a MEM grant while if_req=1, saturating at STARVE_LIMIT.
//   Cleared on an IF grant, or on a MEM grant while if_req=0.
//  ISSUE (1 cycle): ram_en=1, ram_we=1 only for a MEM write. ram_addr/ram_wdata come from the latched values.
//   Store: go to DONE. Read: go to WAIT with wait_cnt=MEM_LATENCY-1.
//  WAIT: decrement wait_cnt. At 0, capture ram_rdata into the granted rdata register and go to DONE.
//   With MEM_LATENCY=1, WAIT lasts 1 cycle and captures in that cycle.
//  DONE (1 cycle): pulse the granted ready, then go to IDLE. Request inputs are ignored in DONE.
//  Latency, request first seen in IDLE at cycle 0: ram_en at cycle 1.
//   Read: ready at cycle MEM_LATENCY+2. Store: ready at cycle 2.
//  Request dropped mid-access: the access still completes and ready still pulses.
//   The unused data is harmless.
//  mem_rd & mem_wr both 1 at a grant: treated as a store, and proto_err is set until reset.
//  The non-granted rdata register is never modified. ram_en=0 in every state except ISSUE.
// TESTING  (MEM_LATENCY=2, STARVE_LIMIT=2 unless noted)
//  IF read 0x40, RAM returns 0xDEADBEEF -> ram_en,addr=0x40,we=0 @c1; if_ready,if_rdata=0xDEADBEEF @c4; stall_if=1 c0-c3
//  IF+MEM read together at c0 -> MEM ram_en @c1, mem_ready @c4; IF ram_en @c6, if_ready @c9
//  Both held continuously, MEM re-requests every time -> grant order MEM,MEM,IF,MEM,MEM,IF
//  Store 0x100/0x12345678 -> @c1 ram_en=1,ram_we=1,ram_addr=0x100,ram_wdata=0x12345678; mem_ready @c2; mem_rdata unchanged
//  rst_n=0 at c2 of an IF read -> from c3: ram_en=0, no if_ready, if_rdata=0; new request at c4 -> ram_en @c5
//  mem_rd=mem_wr=1 addr 0x8 -> ram_we=1 @c1, proto_err=1 from c1 until the next reset

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported synchronous RAM between instruction fetch (IF) and load/store (MEM).
// Latency: ram_en one cycle after the request is sampled; ready at +2 for stores, +MEM_LATENCY+2 for reads.
// Backpressure: requests are held until the one-cycle ready pulse; stall_if/stall_mem flag each waiting stage.
module mem_port_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_ready,
   input  logic                  mem_rd,
   input  logic                  mem_wr,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_ready,
   output logic                  stall_if,
   output logic                  stall_mem,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  proto_err
);

   // wait_cnt must hold MEM_LATENCY-1; keep at least one bit for MEM_LATENCY=1.
   localparam int WCW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int SCW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t          state;
   logic [WCW-1:0]  wait_cnt;
   logic [SCW-1:0]  starve_cnt;
   logic            gnt_mem;
   logic            gnt_wr;
   logic            mem_req;
   logic            if_win;

   // MEM has priority; IF wins only when MEM is idle or IF has been starved long enough.
   assign mem_req   = mem_rd | mem_wr;
   assign if_win    = if_req & (~mem_req | (starve_cnt == SCW'(STARVE_LIMIT)));
   assign stall_if  = if_req & ~if_ready;
   assign stall_mem = mem_req & ~mem_ready;

   // Access sequencer: grant in IDLE, strobe RAM in ISSUE, count read latency in WAIT, pulse ready in DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         starve_cnt <= '0;
         gnt_mem    <= 1'b0;
         gnt_wr     <= 1'b0;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         if_rdata   <= '0;
         mem_rdata  <= '0;
         if_ready   <= 1'b0;
         mem_ready  <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (if_req | mem_req) begin
                  // A simultaneous rd+wr is handled as a store and flagged.
                  gnt_mem   <= ~if_win;
                  gnt_wr    <= ~if_win & mem_wr;
                  ram_en    <= 1'b1;
                  ram_we    <= ~if_win & mem_wr;
                  ram_addr  <= if_win ? if_addr : mem_addr;
                  ram_wdata <= mem_wdata;
                  if (if_win) begin
                     starve_cnt <= '0;
                  end else if (if_req) begin
                     if (starve_cnt != SCW'(STARVE_LIMIT))
                        starve_cnt <= starve_cnt + 1'b1;
                  end else begin
                     starve_cnt <= '0;
                  end
                  if (~if_win & mem_rd & mem_wr)
                     proto_err <= 1'b1;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               ram_en <= 1'b0;
               ram_we <= 1'b0;
               if (gnt_wr) begin
                  mem_ready <= 1'b1;
                  state     <= DONE;
               end else begin
                  wait_cnt <= WCW'(MEM_LATENCY - 1);
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  if (gnt_mem) begin
                     mem_rdata <= ram_rdata;
                     mem_ready <= 1'b1;
                  end else begin
                     if_rdata <= ram_rdata;
                     if_ready <= 1'b1;
                  end
                  state <= DONE;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            DONE: begin
               if_ready  <= 1'b0;
               mem_ready <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: randomized check of mem_port_arbiter against a transaction-level schedule model.
// Latency: model predicts ram_en/ready cycles from the arbitration and latency rules.
// Backpressure: bench requesters hold requests until the predicted ready pulse.
module tb_mem_port_arbiter;

   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int LAT  = 2;
   localparam int SL   = 2;
   localparam int NCYC = 3000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_ready;
   logic          mem_rd;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic          stall_if;
   logic          stall_mem;
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic          proto_err;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .MEM_LATENCY (LAT),
      .STARVE_LIMIT(SL)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_ready (if_ready),
      .mem_rd   (mem_rd),
      .mem_wr   (mem_wr),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready),
      .stall_if (stall_if),
      .stall_mem(stall_mem),
      .ram_en   (ram_en),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata),
      .proto_err(proto_err)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [AW-1:0] rand_addr();
      logic [3:0] w;
      w = 4'($urandom_range(0, 15));
      return {26'd0, w, 2'b00};
   endfunction

   // Reference model: one scheduled transaction at a time, times in absolute cycle numbers.
   logic [DW-1:0] ref_arr [16];
   logic [DW-1:0] ram_arr [16];
   bit            h_en    [16];
   logic [DW-1:0] h_dat   [16];
   int            starve, next_idle;
   bit            t_act, t_mem, t_we, t_proto;
   int            t_en, t_rdy;
   logic [AW-1:0] t_addr;
   logic [DW-1:0] t_wdata, t_rdata;
   logic [DW-1:0] e_if_rdata, e_mem_rdata;
   bit            e_proto, rst_prev_low, proto_phase;
   int            if_st, mem_st;
   bit            e_en, e_ifr, e_memr, m_req, i_win;

   initial begin
      rst_n = 1'b0; if_req = 1'b0; if_addr = '0; mem_rd = 1'b0; mem_wr = 1'b0;
      mem_addr = '0; mem_wdata = '0; ram_rdata = '0;
      for (int i = 0; i < 16; i++) begin
         ref_arr[i] = $urandom;
         ram_arr[i] = ref_arr[i];
         h_en[i]    = 1'b0;
         h_dat[i]   = '0;
      end
      rst_prev_low = 1'b1; proto_phase = 1'b0; t_act = 1'b0; starve = 0; next_idle = 0;
      if_st = 0; mem_st = 0;

      for (int k = 0; k < NCYC + 60; k++) begin
         @(posedge clk);
         #1;
         cyc++;

         // RAM environment: data for a read strobed LAT cycles ago, junk otherwise.
         if (h_en[(cyc + 16 - LAT) % 16]) ram_rdata = h_dat[(cyc + 16 - LAT) % 16];
         else                             ram_rdata = $urandom;

         // Reset seen in the previous cycle takes effect now.
         if (rst_prev_low) begin
            t_act = 1'b0; starve = 0; e_proto = 1'b0; e_if_rdata = '0; e_mem_rdata = '0;
            next_idle = cyc; if_st = 0; mem_st = 0;
            if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
         end

         // Requesters retire their access the cycle after its ready pulse.
         if (t_act && t_rdy == cyc - 1) begin
            if (t_mem) begin mem_st = 0; mem_rd = 1'b0; mem_wr = 1'b0; end
            else       begin if_st = 0;  if_req = 1'b0; end
         end

         if (cyc == NCYC) proto_phase = 1'b1;
         if (cyc < 3 || cyc == NCYC + 30)                      rst_n = 1'b0;
         else if (cyc < NCYC && $urandom_range(0, 299) == 0)   rst_n = 1'b0;
         else                                                  rst_n = 1'b1;

         if (!proto_phase) begin
            if (if_st == 0 && $urandom_range(0, 3) != 0) begin
               if_req = 1'b1; if_addr = rand_addr(); if_st = 1;
            end else if (if_st == 2 && $urandom_range(0, 7) == 0) begin
               if_req = 1'b0; if_addr = $urandom;
            end
         end
         if (mem_st == 0 && $urandom_range(0, 3) != 0) begin
            if (proto_phase) begin
               mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 32'h8;
            end else begin
               mem_wr = 1'($urandom_range(0, 1)); mem_rd = ~mem_wr; mem_addr = rand_addr();
            end
            mem_wdata = $urandom; mem_st = 1;
         end else if (mem_st == 2 && $urandom_range(0, 7) == 0) begin
            mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = $urandom; mem_wdata = $urandom;
         end

         // Schedule a new access when the arbiter is free and someone is asking.
         m_req = mem_rd || mem_wr;
         if (rst_n && cyc >= next_idle && (if_req || m_req)) begin
            i_win = if_req && (!m_req || starve == SL);
            if (i_win)       starve = 0;
            else if (if_req) starve = (starve < SL) ? starve + 1 : SL;
            else             starve = 0;
            t_act   = 1'b1;
            t_mem   = !i_win;
            t_we    = t_mem && mem_wr;
            t_proto = t_mem && mem_rd && mem_wr;
            t_addr  = i_win ? if_addr : mem_addr;
            t_wdata = mem_wdata;
            t_en    = cyc + 1;
            t_rdy   = t_we ? cyc + 2 : cyc + LAT + 2;
            if (t_we) ref_arr[t_addr[5:2]] = t_wdata;
            else      t_rdata = ref_arr[t_addr[5:2]];
            if (i_win) if_st = 2; else mem_st = 2;
            next_idle = t_rdy + 1;
         end

         @(negedge clk);
         e_en   = t_act && cyc == t_en;
         e_ifr  = t_act && cyc == t_rdy && !t_mem;
         e_memr = t_act && cyc == t_rdy && t_mem;
         if (e_en && t_proto) e_proto = 1'b1;
         if (t_act && cyc == t_rdy && !t_we) begin
            if (t_mem) e_mem_rdata = t_rdata;
            else       e_if_rdata  = t_rdata;
         end

         check_val("ram_en", ram_en, e_en);
         if (e_en) begin
            check_val("ram_we", ram_we, t_we);
            check_val("ram_addr", ram_addr, t_addr);
            if (t_we) check_val("ram_wdata", ram_wdata, t_wdata);
         end
         check_val("if_ready", if_ready, e_ifr);
         check_val("mem_ready", mem_ready, e_memr);
         check_val("if_rdata", if_rdata, e_if_rdata);
         check_val("mem_rdata", mem_rdata, e_mem_rdata);
         check_val("stall_if", stall_if, if_req && !e_ifr);
         check_val("stall_mem", stall_mem, (mem_rd || mem_wr) && !e_memr);
         check_val("proto_err", proto_err, e_proto);
         if (cyc == 1) begin
            check_val("rst_ram_we", ram_we, 1'b0);
            check_val("rst_ram_addr", ram_addr, '0);
            check_val("rst_ram_wdata", ram_wdata, '0);
         end

         // RAM environment follows whatever the DUT actually strobes.
         h_en[cyc % 16] = (ram_en === 1'b1) && (ram_we !== 1'b1);
         if (ram_en === 1'b1) begin
            if (ram_we === 1'b1) ram_arr[ram_addr[5:2]] = ram_wdata;
            else                 h_dat[cyc % 16] = ram_arr[ram_addr[5:2]];
         end
         rst_prev_low = !rst_n;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
